// File: rtl/lfsr_word_gen_pkg.sv
// Shared definitions for the LFSR word generator: FSM encoding and
// reference Galois tap masks for common state widths.
package lfsr_word_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fsm_state_t;

  // Right-shifting Galois masks for maximal-length sequences
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'hA300_0000;

endpackage

// File: rtl/lfsr_word_gen_register.sv
// Plain state register with an active-low synchronous reset and a fixed
// reset value; the owner supplies the next value every cycle.
module lfsr_word_gen_register #(
  parameter int                  NUM_BITS = 16,
  parameter logic [NUM_BITS-1:0] RST_VAL  = {NUM_BITS{1'b1}}
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_BITS-1:0] i_write_data,
  output logic [NUM_BITS-1:0] o_read_data
);

  logic [NUM_BITS-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= i_write_data;
    end
  end

  assign o_read_data = r_q;

endmodule

// File: rtl/lfsr_word_gen.sv
// Galois LFSR word source with runtime reseed, a zero-seed guard and a
// two-entry registered output FIFO on a valid/ready stream.
module lfsr_word_gen
  import lfsr_word_gen_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int               STEPS        = 1,
  parameter int               OUT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_zero_seed,
  output logic [31:0]      o_gen_count
);

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? TAPS : {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] w_state;
  logic [WIDTH-1:0] w_next_state;
  logic [WIDTH-1:0] w_write_data;
  logic [WIDTH-1:0] w_seed_val;
  logic             w_pop;
  logic             w_advance;
  logic [1:0]       w_count_nxt;
  logic [OUT_W-1:0] w_slot0_nxt;
  logic [OUT_W-1:0] w_slot1_nxt;
  fsm_state_t       w_fsm_nxt;
  logic [31:0]      w_gen_nxt;

  logic [1:0]       r_count;
  logic [OUT_W-1:0] r_slot0;
  logic [OUT_W-1:0] r_slot1;
  logic             r_out_valid;
  logic             r_zero_seed;
  logic [31:0]      r_gen_count;
  fsm_state_t       r_fsm_state;

  lfsr_word_gen_register #(
    .NUM_BITS (WIDTH),
    .RST_VAL  (SEED_DEFAULT)
  ) u_state_reg (
    .i_clk        (i_clk),
    .i_rst_n      (~i_rst),
    .i_write_data (w_write_data),
    .o_read_data  (w_state)
  );

  assign w_pop      = (r_count != 2'd0) && i_out_ready;
  assign w_advance  = i_enable && !i_seed_load && ((r_count != 2'd2) || w_pop);
  assign w_seed_val = (i_seed_data == {WIDTH{1'b0}}) ? SEED_DEFAULT : i_seed_data;

  always_comb begin
    w_next_state = w_state;
    for (int i = 0; i < STEPS; i++) begin
      w_next_state = galois_step(w_next_state);
    end
  end

  always_comb begin
    if (i_seed_load) begin
      w_write_data = w_seed_val;
    end else if (w_advance) begin
      w_write_data = w_next_state;
    end else begin
      w_write_data = w_state;
    end
  end

  // Pop shifts the tail forward (zero refills so an empty head reads 0),
  // then a push lands in the first free slot; a seed flushes after the pop.
  always_comb begin
    w_count_nxt = r_count;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (w_pop) begin
      w_slot0_nxt = r_slot1;
      w_slot1_nxt = {OUT_W{1'b0}};
      w_count_nxt = r_count - 2'd1;
    end else begin
      w_count_nxt = r_count;
    end
    if (w_advance) begin
      if (w_count_nxt == 2'd0) begin
        w_slot0_nxt = w_next_state[OUT_W-1:0];
      end else begin
        w_slot1_nxt = w_next_state[OUT_W-1:0];
      end
      w_count_nxt = w_count_nxt + 2'd1;
    end else begin
      w_count_nxt = w_count_nxt;
    end
    if (i_seed_load) begin
      w_count_nxt = 2'd0;
      w_slot0_nxt = {OUT_W{1'b0}};
      w_slot1_nxt = {OUT_W{1'b0}};
    end else begin
      w_count_nxt = w_count_nxt;
    end
  end

  always_comb begin
    if (i_seed_load) begin
      w_gen_nxt = 32'd0;
    end else if (w_advance && (r_gen_count != 32'hFFFF_FFFF)) begin
      w_gen_nxt = r_gen_count + 32'd1;
    end else begin
      w_gen_nxt = r_gen_count;
    end
  end

  always_comb begin
    if (!i_enable) begin
      w_fsm_nxt = S_IDLE;
    end else if (i_seed_load) begin
      w_fsm_nxt = S_RUN;
    end else if ((w_count_nxt == 2'd2) && !w_pop) begin
      w_fsm_nxt = S_STALL;
    end else begin
      w_fsm_nxt = S_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= 2'd0;
      r_slot0     <= {OUT_W{1'b0}};
      r_slot1     <= {OUT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_zero_seed <= 1'b0;
      r_gen_count <= 32'd0;
      r_fsm_state <= S_IDLE;
    end else begin
      r_count     <= w_count_nxt;
      r_slot0     <= w_slot0_nxt;
      r_slot1     <= w_slot1_nxt;
      r_out_valid <= (w_count_nxt != 2'd0);
      r_zero_seed <= r_zero_seed || (i_seed_load && (i_seed_data == {WIDTH{1'b0}}));
      r_gen_count <= w_gen_nxt;
      r_fsm_state <= w_fsm_nxt;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_slot0;
  assign o_zero_seed = r_zero_seed;
  assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Directed bench for lfsr_word_gen: a scoreboard of expected words from a
// bench-side LFSR model, plus stall, reseed, reset and full-period checks.
module tb_lfsr_word_gen;
  import lfsr_word_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, seed_load, out_ready;
  logic [15:0] seed_data;
  logic        out_valid, zero_seed;
  logic [7:0]  out_data;
  logic [31:0] gen_count;

  logic        rst2, enable2;
  logic        out_valid2, zero_seed2;
  logic [15:0] out_data2;
  logic [31:0] gen_count2;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_log[$];

  always #5 clk = ~clk;

  lfsr_word_gen dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
    .i_seed_data(seed_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_zero_seed(zero_seed), .o_gen_count(gen_count)
  );

  lfsr_word_gen #(.STEPS(16), .OUT_W(16)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_enable(enable2), .i_seed_load(1'b0),
    .i_seed_data(16'h0000), .o_out_valid(out_valid2), .i_out_ready(1'b1),
    .o_out_data(out_data2), .o_zero_seed(zero_seed2), .o_gen_count(gen_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic refill(input logic [15:0] seed);
    logic [15:0] s;
    s = seed;
    exp_q.delete();
    obs_log.delete();
    for (int i = 0; i < 64; i++) begin
      s = model_step(s);
      exp_q.push_back(s[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake must deliver the next expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'(out_data), 32'hDEAD);
      end else begin
        check("sb_word", 32'(out_data), 32'(exp_q.pop_front()));
      end
      obs_log.push_back(out_data);
    end
  end

  initial begin
    logic [7:0] seq1 [6];
    int bad;
    seq1 = '{8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13};
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_data = 16'h0; out_ready = 1'b0;
    rst2 = 1'b1; enable2 = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_gen", gen_count, 32'd0);
    check("rst_zero", 32'(zero_seed), 32'd0);
    check("rst_fsm", 32'(dut.r_fsm_state), 32'(S_IDLE));
    check("rst_state", 32'(dut.w_state), 32'hACE1);

    // 1) free-running stream
    rst = 1'b0; refill(16'hACE1); enable = 1'b1; out_ready = 1'b1;
    repeat (6) tick();
    check("t1_gen", gen_count, 32'd6);
    check("t1_head", 32'(out_data), 32'h13);
    check("t1_state", 32'(dut.w_state), 32'hB313);
    tick();
    for (int i = 0; i < 6; i++) check("t1_seq", 32'(obs_log[i]), 32'(seq1[i]));

    // 2) back-pressure fills the FIFO and stalls
    rst = 1'b1; tick(); rst = 1'b0; refill(16'hACE1); out_ready = 1'b0;
    repeat (10) tick();
    check("t2_gen", gen_count, 32'd2);
    check("t2_fsm", 32'(dut.r_fsm_state), 32'(S_STALL));
    check("t2_hold", 32'(out_data), 32'h70);
    check("t2_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("t2_n", 32'(obs_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("t2_seq", 32'(obs_log[i]), 32'(seq1[i]));

    // 3) zero seed is substituted and flagged
    out_ready = 1'b0; seed_load = 1'b1; seed_data = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("t3_zero", 32'(zero_seed), 32'd1);
    check("t3_state", 32'(dut.w_state), 32'hACE1);
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_gen", gen_count, 32'd0);
    check("t3_fsm", 32'(dut.r_fsm_state), 32'(S_RUN));
    refill(16'hACE1); out_ready = 1'b1;
    repeat (3) tick();
    check("t3_w0", 32'(obs_log[0]), 32'h70);
    check("t3_w1", 32'(obs_log[1]), 32'h38);
    out_ready = 1'b0; seed_load = 1'b1; seed_data = 16'hACE1;
    tick();
    seed_load = 1'b0;
    check("t3_sticky", 32'(zero_seed), 32'd1);

    // 4) seed on the same edge as a transfer with a full FIFO
    refill(16'hACE1);
    tick(); tick();
    check("t4_full", 32'(dut.r_fsm_state), 32'(S_STALL));
    out_ready = 1'b1; seed_load = 1'b1; seed_data = 16'h1234;
    tick();
    seed_load = 1'b0;
    check("t4_popped", 32'(obs_log.size()), 32'd1);
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_gen", gen_count, 32'd0);
    refill(16'h1234);
    tick();
    check("t4_valid1", 32'(out_valid), 32'd1);
    check("t4_gen1", gen_count, 32'd1);
    check("t4_sticky", 32'(zero_seed), 32'd1);

    // 5) reset mid-stream discards buffered words
    repeat (3) tick();
    check("t5_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_data", 32'(out_data), 32'd0);
    check("t5_gen", gen_count, 32'd0);
    check("t5_zero", 32'(zero_seed), 32'd0);
    rst = 1'b0; refill(16'hACE1);
    repeat (3) tick();
    check("t5_n", 32'(obs_log.size()), 32'd2);
    check("t5_w0", 32'(obs_log[0]), 32'h70);
    enable = 1'b0; out_ready = 1'b0;

    // 6) 16 steps per advance still walks the full maximal period
    rst2 = 1'b0; enable2 = 1'b1; bad = 0;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (dut2.w_state == 16'h0000 || (k < 65535 && dut2.w_state == 16'hACE1)) bad++;
    end
    check("t6_bad", 32'(bad), 32'd0);
    check("t6_state", 32'(dut2.w_state), 32'hACE1);
    check("t6_gen", gen_count2, 32'd65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
